// File: rtl/blake_pkg.sv
// rtl/blake_pkg.sv - shared widths, shift FSM states and work-word packing for the work dispatcher
package blake_pkg;

    localparam int MIDSTATE_W = 256;
    localparam int DATA_W     = 96;
    localparam int NONCE_W    = 32;
    localparam int WORK_BITS  = 384;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_t;

    // Order in which the cores expect the serial work word, MSB first.
    function automatic logic [WORK_BITS-1:0] work_word(
        input logic [MIDSTATE_W-1:0] midstate,
        input logic [NONCE_W-1:0]    nonce,
        input logic [DATA_W-1:0]     data
    );
        return {midstate, nonce, data};
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// rtl/nonce_fifo.sv - show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             hash_clk,
    input  logic             reset,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [WIDTH-1:0] in_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [WIDTH-1:0] out_tdata
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign out_tvalid = (count != '0);
    assign out_tdata  = mem[rd_ptr];
    assign do_pop     = out_tvalid && out_tready;
    assign in_tready  = (count != (PTR_W+1)'(DEPTH)) || do_pop;
    assign do_push    = in_tvalid && in_tready;

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge hash_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

endmodule

// File: rtl/multicore_work_dispatch.sv
// rtl/multicore_work_dispatch.sv - serialises work to hash cores and gathers their golden nonces into a FIFO
module multicore_work_dispatch
    import blake_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         hash_clk,
    input  logic                         reset,
    input  logic                         new_work,
    input  logic [MIDSTATE_W-1:0]        midstate,
    input  logic [DATA_W-1:0]            data,
    input  logic [NONCE_W-1:0]           initial_nonce,
    output logic                         core_din,
    output logic                         core_shift,
    output logic                         core_loadnonce,
    input  logic [NUM_CORES-1:0]         core_match,
    input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    output logic                         nonce_valid,
    output logic [NONCE_W-1:0]           nonce_out,
    input  logic                         nonce_ack,
    output logic                         busy,
    output logic                         overflow
);

    localparam int         IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [8:0] LAST_SHIFT = 9'(WORK_BITS - 1);

    shift_state_t           state_q;
    shift_state_t           state_d;
    logic [WORK_BITS-1:0]   shreg_q;
    logic [8:0]             shift_cnt_q;
    logic                   loadnonce_q;

    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        core_shift = 1'b0;
        core_din   = 1'b0;
        if (state_q == SHIFT) begin
            busy       = 1'b1;
            core_shift = 1'b1;
            core_din   = shreg_q[WORK_BITS-1];
        end
        if (new_work) begin
            state_d = SHIFT;
        end else if (state_q == SHIFT && shift_cnt_q == LAST_SHIFT) begin
            state_d = IDLE;
        end
    end

    // A new_work in SHIFT reloads and restarts; the abandoned word never finishes.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            shift_cnt_q <= '0;
            loadnonce_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            loadnonce_q <= new_work;
            if (new_work) begin
                shreg_q     <= work_word(midstate, initial_nonce, data);
                shift_cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                shreg_q     <= {shreg_q[WORK_BITS-2:0], 1'b0};
                shift_cnt_q <= shift_cnt_q + 1'b1;
            end
        end
    end

    assign core_loadnonce = loadnonce_q;

    logic [NUM_CORES-1:0]         match_q;
    logic [NUM_CORES*NONCE_W-1:0] match_nonce_q;
    logic [NUM_CORES-1:0]         hold_valid_q;
    logic [NONCE_W-1:0]           hold_nonce_q [NUM_CORES];
    logic [IDX_W-1:0]             rr_ptr_q;
    logic [NUM_CORES-1:0]         grant;
    logic                         push_valid;
    logic [NONCE_W-1:0]           push_nonce;
    logic                         fifo_in_tready;
    logic                         overflow_q;

    // rr_ptr_q names the first core searched: one past the last granted core.
    always_comb begin
        int cand;
        cand       = 0;
        grant      = '0;
        push_valid = 1'b0;
        push_nonce = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_CORES;
            if (!push_valid && fifo_in_tready && hold_valid_q[cand]) begin
                push_valid  = 1'b1;
                grant[cand] = 1'b1;
                push_nonce  = hold_nonce_q[cand];
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            match_q      <= '0;
            hold_valid_q <= '0;
            rr_ptr_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            match_q <= core_match;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (match_q[i]) begin
                    if (hold_valid_q[i] && !grant[i]) begin
                        overflow_q <= 1'b1;
                    end else begin
                        hold_valid_q[i] <= 1'b1;
                    end
                end else if (grant[i]) begin
                    hold_valid_q[i] <= 1'b0;
                end
                if (grant[i]) begin
                    rr_ptr_q <= (i == NUM_CORES - 1) ? '0 : IDX_W'(i + 1);
                end
            end
        end
    end

    // A hold slot being granted this cycle frees up in time to take a new match.
    always_ff @(posedge hash_clk) begin
        match_nonce_q <= core_nonce;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (match_q[i] && (!hold_valid_q[i] || grant[i])) begin
                hold_nonce_q[i] <= match_nonce_q[i*NONCE_W +: NONCE_W];
            end
        end
    end

    assign overflow = overflow_q;

    nonce_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_nonce_fifo (
        .hash_clk   (hash_clk),
        .reset      (reset),
        .in_tvalid  (push_valid),
        .in_tready  (fifo_in_tready),
        .in_tdata   (push_nonce),
        .out_tvalid (nonce_valid),
        .out_tready (nonce_ack),
        .out_tdata  (nonce_out)
    );

endmodule

// File: tb/tb_multicore_work_dispatch.sv
// tb/tb_multicore_work_dispatch.sv - randomized self-checking bench for multicore_work_dispatch
module tb_multicore_work_dispatch;

    localparam int NC    = 4;
    localparam int DEPTH = 4;

    logic           hash_clk = 1'b0;
    logic           reset;
    logic           new_work;
    logic [255:0]   midstate;
    logic [95:0]    data;
    logic [31:0]    initial_nonce;
    logic           core_din;
    logic           core_shift;
    logic           core_loadnonce;
    logic [NC-1:0]  core_match;
    logic [NC*32-1:0] core_nonce;
    logic           nonce_valid;
    logic [31:0]    nonce_out;
    logic           nonce_ack;
    logic           busy;
    logic           overflow;

    int total = 0;
    int bad   = 0;

    multicore_work_dispatch #(.NUM_CORES(NC), .FIFO_DEPTH(DEPTH)) dut (
        .hash_clk       (hash_clk),
        .reset          (reset),
        .new_work       (new_work),
        .midstate       (midstate),
        .data           (data),
        .initial_nonce  (initial_nonce),
        .core_din       (core_din),
        .core_shift     (core_shift),
        .core_loadnonce (core_loadnonce),
        .core_match     (core_match),
        .core_nonce     (core_nonce),
        .nonce_valid    (nonce_valid),
        .nonce_out      (nonce_out),
        .nonce_ack      (nonce_ack),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    function automatic logic [383:0] rand_word();
        logic [383:0] w;
        for (int i = 0; i < 12; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic drive_work(input logic [383:0] w);
        midstate      = w[383:128];
        initial_nonce = w[127:96];
        data          = w[95:0];
        new_work      = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; new_work = 1'b0; core_match = '0; nonce_ack = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; new_work = 1'b1; core_match = '0; core_nonce = '0; nonce_ack = 1'b0;
        midstate = '1; data = '1; initial_nonce = '1;
        step(); step();
        total++;
        if ({core_shift, core_loadnonce, core_din, busy, nonce_valid, overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {core_shift, core_loadnonce, core_din, busy, nonce_valid, overflow});
        end
        reset = 1'b0; new_work = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || core_loadnonce !== 1'b0) begin
            bad++;
            $display("FAIL reset_priority: busy=%b loadnonce=%b want 0 0", busy, core_loadnonce);
        end
    endtask

    task automatic test_shift_vector();
        logic [383:0] w;
        int loads, errs;
        w = {256'h3171e68374c4f0c0d3ac3c4a14f7b4b7f8cf90e4d5f2a3fdf3c0a1b2f0ea633b,
             32'hffbd9207, 96'hffff001e11f35052d554469e};
        drive_work(w);
        step();
        new_work = 1'b0;
        loads = 0; errs = 0;
        total++;
        if (core_loadnonce !== 1'b1) begin
            bad++;
            $display("FAIL vec_loadnonce_first: got %b want 1", core_loadnonce);
        end
        for (int i = 0; i < 384; i++) begin
            if (core_loadnonce === 1'b1) loads++;
            if (core_shift !== 1'b1 || core_din !== w[383-i]) errs++;
            step();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL vec_bits: %0d wrong shift cycles, want 0", errs);
        end
        total++;
        if (loads != 1) begin
            bad++;
            $display("FAIL vec_loadnonce_count: got %0d want 1", loads);
        end
        total++;
        if (busy !== 1'b0 || core_shift !== 1'b0) begin
            bad++;
            $display("FAIL vec_done: busy=%b shift=%b want 0 0", busy, core_shift);
        end
    endtask

    task automatic test_restart();
        logic [383:0] wa, wb;
        int loads, errs_a, errs_b;
        wa = rand_word(); wb = rand_word();
        drive_work(wa);
        step();
        new_work = 1'b0;
        loads = 0; errs_a = 0; errs_b = 0;
        for (int i = 0; i <= 200; i++) begin
            if (core_loadnonce === 1'b1) loads++;
            if (core_shift !== 1'b1 || core_din !== wa[383-i]) errs_a++;
            if (i == 200) drive_work(wb);
            step();
            new_work = 1'b0;
        end
        total++;
        if (core_loadnonce !== 1'b1) begin
            bad++;
            $display("FAIL restart_loadnonce: got %b want 1", core_loadnonce);
        end
        for (int j = 0; j < 384; j++) begin
            if (core_loadnonce === 1'b1) loads++;
            if (core_shift !== 1'b1 || core_din !== wb[383-j]) errs_b++;
            step();
        end
        total++;
        if (errs_a != 0 || errs_b != 0) begin
            bad++;
            $display("FAIL restart_bits: old=%0d new=%0d wrong cycles, want 0 0", errs_a, errs_b);
        end
        total++;
        if (loads != 2) begin
            bad++;
            $display("FAIL restart_loads: got %0d want 2", loads);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_done: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_match();
        logic [2:0] seen;
        do_reset();
        core_match = 4'b0001;
        core_nonce = {$urandom, $urandom, $urandom, 32'h12345678};
        step();
        core_match = '0;
        core_nonce = {$urandom, $urandom, $urandom, $urandom};
        seen[0] = nonce_valid;
        step();
        seen[1] = nonce_valid;
        step();
        seen[2] = nonce_valid;
        total++;
        if (seen !== 3'b100 || nonce_out !== 32'h12345678) begin
            bad++;
            $display("FAIL match_latency: valid c3..c1=%b nonce=%h want 100 12345678", seen, nonce_out);
        end
        nonce_ack = 1'b1;
        step();
        nonce_ack = 1'b0;
        total++;
        if (nonce_valid !== 1'b0) begin
            bad++;
            $display("FAIL match_ack: valid=%b want 0", nonce_valid);
        end
    endtask

    task automatic test_all_match();
        do_reset();
        core_match = 4'b1111;
        core_nonce = {32'd4, 32'd3, 32'd2, 32'd1};
        step();
        core_match = '0;
        repeat (6) step();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (nonce_valid !== 1'b1 || nonce_out !== 32'(k + 1)) begin
                bad++;
                $display("FAIL all_match_order[%0d]: valid=%b nonce=%h want 1 %h",
                         k, nonce_valid, nonce_out, 32'(k + 1));
            end
            nonce_ack = 1'b1;
            step();
            nonce_ack = 1'b0;
        end
        total++;
        if (nonce_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL all_match_end: valid=%b overflow=%b want 0 0", nonce_valid, overflow);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_q [5];
        exp_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hC2C2_0001};
        do_reset();
        core_match = 4'b1111;
        core_nonce = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        step();
        core_match = '0;
        repeat (6) step();
        core_match = 4'b0100;
        core_nonce = {32'h0, 32'hC2C2_0001, 64'h0};
        step();
        core_match = '0;
        repeat (3) step();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_first_held: overflow=%b want 0", overflow);
        end
        core_match = 4'b0100;
        core_nonce = {32'h0, 32'hC2C2_0002, 64'h0};
        step();
        core_match = '0;
        repeat (2) step();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: overflow=%b want 1", overflow);
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (nonce_valid !== 1'b1 || nonce_out !== exp_q[k]) begin
                bad++;
                $display("FAIL ovf_drain[%0d]: valid=%b nonce=%h want 1 %h",
                         k, nonce_valid, nonce_out, exp_q[k]);
            end
            nonce_ack = 1'b1;
            step();
            nonce_ack = 1'b0;
            step();
        end
        total++;
        if (nonce_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_end: valid=%b overflow=%b want 0 1", nonce_valid, overflow);
        end
    endtask

    task automatic test_reset_midshift();
        do_reset();
        core_match = 4'b0011;
        core_nonce = {64'h0, 32'h0000_0B0B, 32'h0000_0A0A};
        step();
        core_match = '0;
        repeat (4) step();
        drive_work(rand_word());
        step();
        new_work = 1'b0;
        repeat (100) step();
        total++;
        if (busy !== 1'b1 || nonce_valid !== 1'b1) begin
            bad++;
            $display("FAIL midshift_pre: busy=%b valid=%b want 1 1", busy, nonce_valid);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({core_shift, busy, nonce_valid, overflow, core_loadnonce, core_din} !== 6'b0) begin
            bad++;
            $display("FAIL midshift_reset: got %b want 000000",
                     {core_shift, busy, nonce_valid, overflow, core_loadnonce, core_din});
        end
    endtask

    // Reference: per-core one-deep holds, a FIFO queue, round-robin from one past the last grant.
    task automatic test_random_traffic(input int cycles, input int match_den, input int ack_pct);
        logic [31:0] q [$];
        bit          hv [NC];
        logic [31:0] hn [NC];
        int          rr, g, errs_v, errs_d, errs_o;
        bit          ovf, pop;
        logic [NC-1:0]    pm;
        logic [NC*32-1:0] pn;
        do_reset();
        q.delete();
        for (int i = 0; i < NC; i++) hv[i] = 0;
        rr = 0; ovf = 0; pm = '0; pn = '0;
        errs_v = 0; errs_d = 0; errs_o = 0;
        for (int c = 0; c < cycles; c++) begin
            core_match = ($urandom_range(0, match_den - 1) == 0) ? NC'($urandom) : '0;
            for (int i = 0; i < NC; i++) core_nonce[i*32 +: 32] = $urandom;
            nonce_ack = ($urandom_range(0, 99) < ack_pct);
            if ($urandom_range(0, 199) == 0) drive_work(rand_word());
            else new_work = 1'b0;

            pop = nonce_ack && (q.size() > 0);
            g = -1;
            if (q.size() < DEPTH || pop) begin
                for (int k = 0; k < NC; k++) begin
                    if (g < 0 && hv[(rr + k) % NC]) g = (rr + k) % NC;
                end
            end
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back(hn[g]);
                hv[g] = 0;
                rr = (g + 1) % NC;
            end
            for (int i = 0; i < NC; i++) begin
                if (pm[i]) begin
                    if (hv[i]) ovf = 1;
                    else begin
                        hv[i] = 1;
                        hn[i] = pn[i*32 +: 32];
                    end
                end
            end
            pm = core_match;
            pn = core_nonce;

            step();
            if (nonce_valid !== (q.size() > 0)) errs_v++;
            else if (q.size() > 0 && nonce_out !== q[0]) errs_d++;
            if (overflow !== ovf) errs_o++;
        end
        new_work = 1'b0; core_match = '0; nonce_ack = 1'b0;
        total++;
        if (errs_v != 0) begin
            bad++;
            $display("FAIL rand_valid(den=%0d): %0d wrong cycles, want 0", match_den, errs_v);
        end
        total++;
        if (errs_d != 0) begin
            bad++;
            $display("FAIL rand_nonce(den=%0d): %0d wrong cycles, want 0", match_den, errs_d);
        end
        total++;
        if (errs_o != 0) begin
            bad++;
            $display("FAIL rand_overflow(den=%0d): %0d wrong cycles, want 0", match_den, errs_o);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; new_work = 1'b0; core_match = '0; core_nonce = '0; nonce_ack = 1'b0;
        midstate = '0; data = '0; initial_nonce = '0;
        test_reset();
        test_shift_vector();
        test_restart();
        test_single_match();
        test_all_match();
        test_overflow();
        test_reset_midshift();
        test_random_traffic(1500, 16, 80);
        test_random_traffic(1500, 3, 30);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicore_work_dispatch.md
MULTICORE_WORK_DISPATCH -- requirements
Module: multicore_work_dispatch

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of hash cores served (legal range 1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, golden-nonce FIFO entries (power of two, 2..16).
REQ-003 SHALL have port hash_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port new_work  input  1  single-cycle strobe: midstate/data/initial_nonce valid.
REQ-006 SHALL have port midstate  input  256  work midstate.
REQ-007 SHALL have port data  input  96  work data tail.
REQ-008 SHALL have port initial_nonce  input  32  starting nonce field.
REQ-009 SHALL have port core_din  output  1  shared serial work bit to all cores.
REQ-010 SHALL have port core_shift  output  1  shared shift enable to all cores.
REQ-011 SHALL have port core_loadnonce  output  1  shared nonce-load pulse to all cores.
REQ-012 SHALL have port core_match  input  NUM_CORES  per-core golden-nonce flag.
REQ-013 SHALL have port core_nonce  input  NUM_CORES*32  per-core golden nonce; core i at bits [32i+31:32i].
REQ-014 SHALL have port nonce_valid  output  1  FIFO head valid.
REQ-015 SHALL have port nonce_out  output  32  FIFO head nonce.
REQ-016 SHALL have port nonce_ack  input  1  pops head when nonce_valid high.
REQ-017 SHALL have port busy  output  1  high while the work shift is in progress.
REQ-018 SHALL have port overflow  output  1  sticky flag: a golden nonce was dropped.

Function
REQ-019 Shift FSM SHALL have states IDLE and SHIFT.
REQ-020 When new_work is sampled high, the block SHALL load the 384-bit shift register with {midstate, initial_nonce, data}, MSB first, and SHALL enter SHIFT.
REQ-021 In SHIFT, core_shift SHALL be high for exactly 384 consecutive cycles, starting the cycle after new_work; each cycle SHALL present the current MSB on core_din and shift left by one (zero fill).
REQ-022 The FSM SHALL return to IDLE after the 384th shift cycle; busy SHALL equal (state == SHIFT).
REQ-023 core_loadnonce SHALL be high for exactly one cycle, the cycle after new_work is sampled.
REQ-024 A new_work arriving in SHIFT SHALL reload the register, restart the 384-cycle count from zero, and pulse core_loadnonce again; the old work is abandoned.
REQ-025 core_match SHALL be registered; on a registered match, core i's nonce SHALL be latched into a one-deep per-core hold register.
REQ-026 Hold registers SHALL push to the FIFO one per cycle, round-robin starting after the last granted core; no push SHALL occur while the FIFO is full.
REQ-027 If a core matches while its hold register is still occupied and is not being granted that cycle, the new nonce SHALL be dropped and overflow SHALL be set.
REQ-028 overflow SHALL remain set until reset.
REQ-029 The FIFO SHALL be show-ahead: nonce_valid = not empty, and nonce_out = head.
REQ-030 nonce_ack with nonce_valid low SHALL be ignored; a simultaneous push and pop on a full FIFO SHALL be permitted.
REQ-031 Latency from core_match high to nonce_valid high SHALL be exactly 3 cycles when the FIFO is empty and there is no contention.
REQ-032 new_work SHALL NOT flush the hold registers or the FIFO.

Reset
REQ-033 Reset SHALL force: FSM to IDLE, core_shift=0, core_loadnonce=0, core_din=0, busy=0, all hold registers empty, FIFO empty, nonce_valid=0, overflow=0, round-robin pointer to core 0.
REQ-034 Reset SHALL take priority over a simultaneous new_work; a reset during SHIFT SHALL abort the shift immediately.

Structure
REQ-035 Package blake_pkg SHALL define MIDSTATE_W=256, DATA_W=96, NONCE_W=32, WORK_BITS=384.
REQ-036 The FIFO SHALL be the single sub-module nonce_fifo, parametrised by width and depth.

Verification
REQ-037 new_work with midstate=256'h3171e683...f0ea633b, data=96'hffff001e11f35052d554469e, initial_nonce=32'hffbd9207 -> core_loadnonce pulses once; core_din over 384 shift cycles reproduces {midstate, nonce, data} exactly; busy low after the last shift.
REQ-038 Second new_work at shift cycle 200 -> count restarts; exactly 384 further shift cycles of the new word; a second loadnonce pulse.
REQ-039 core_match=4'b0001, nonce 32'h12345678, FIFO empty -> nonce_valid high 3 cycles later with nonce_out=32'h12345678; nonce_ack clears nonce_valid the next cycle.
REQ-040 All 4 cores match in the same cycle with nonces 1,2,3,4 -> four FIFO entries in round-robin order 1,2,3,4; overflow stays 0.
REQ-041 FIFO full (4 entries, no ack) and core 2 matches twice -> the second nonce is dropped and overflow=1; after acks, the first core-2 nonce still emerges.
REQ-042 Reset asserted at shift cycle 100 with 2 FIFO entries -> next cycle core_shift=0, busy=0, nonce_valid=0, overflow=0.
